// File: rtl/gates_mux_sweeper_if.sv
// Handshake/bus bundle between the sweeper and its driver/observer.
// The master drives start/abort/y. The slave (the sweeper) drives the mux vector and the results.
interface gates_mux_sweeper_if;
   logic        start;
   logic        abort;
   logic        y;
   logic        a;
   logic        b;
   logic [1:0]  sel;
   logic        busy;
   logic        done;
   logic [15:0] table_out;
   logic        table_valid;
   logic        match;

   modport master (
      output start, abort, y,
      input  a, b, sel, busy, done, table_out, table_valid, match
   );

   modport slave (
      input  start, abort, y,
      output a, b, sel, busy, done, table_out, table_valid, match
   );
endinterface

// File: rtl/gates_mux_sweeper.sv
// Walks all 16 {sel,a,b} vectors into gates_mux and captures y after SETTLE extra cycles.
// It then compares the captured truth table against EXPECT.
module gates_mux_sweeper #(
   parameter int unsigned SETTLE = 1,
   parameter logic [15:0] EXPECT = 16'h76E8
) (
   input  logic                clk,
   input  logic                rst_n,
   gates_mux_sweeper_if.slave  sw
);

   localparam logic [3:0] SETTLE_C = SETTLE[3:0];

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t      r_state;
   logic [3:0]  r_idx;
   logic [3:0]  r_cnt;
   logic        r_a;
   logic        r_b;
   logic [1:0]  r_sel;
   logic        r_busy;
   logic        r_done;
   logic [15:0] r_table;
   logic        r_valid;
   logic        r_match;
   logic [15:0] w_tbl;

   // Table as it will look once the current sample lands.
   always_comb begin
      w_tbl        = r_table;
      w_tbl[r_idx] = sw.y;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_a     <= 1'b0;
         r_b     <= 1'b0;
         r_sel   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_table <= '0;
         r_valid <= 1'b0;
         r_match <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (sw.start) begin
                  r_state            <= S_RUN;
                  r_idx              <= '0;
                  r_cnt              <= '0;
                  {r_sel, r_a, r_b}  <= '0;
                  r_busy             <= 1'b1;
                  r_valid            <= 1'b0;
                  r_match            <= 1'b0;
                  r_table            <= '0;
               end
            end
            S_RUN: begin
               // Abort beats a sample on the same edge; the partial table is kept.
               if (sw.abort) begin
                  r_state           <= S_IDLE;
                  r_busy            <= 1'b0;
                  {r_sel, r_a, r_b} <= '0;
                  r_valid           <= 1'b0;
                  r_match           <= 1'b0;
               end else if (r_cnt != SETTLE_C) begin
                  r_cnt <= r_cnt + 4'd1;
               end else begin
                  r_table <= w_tbl;
                  r_match <= (w_tbl == EXPECT);
                  if (r_idx != 4'd15) begin
                     r_idx             <= r_idx + 4'd1;
                     r_cnt             <= '0;
                     {r_sel, r_a, r_b} <= r_idx + 4'd1;
                  end else begin
                     r_state           <= S_IDLE;
                     r_busy            <= 1'b0;
                     r_done            <= 1'b1;
                     r_valid           <= 1'b1;
                     {r_sel, r_a, r_b} <= '0;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign sw.a           = r_a;
   assign sw.b           = r_b;
   assign sw.sel         = r_sel;
   assign sw.busy        = r_busy;
   assign sw.done        = r_done;
   assign sw.table_out   = r_table;
   assign sw.table_valid = r_valid;
   assign sw.match       = r_match;

endmodule
